// File: rtl/spidlg_tx.sv
// DLG2416 serial transmitter: shifts {Cmd,Data} MSB-first on Dclk/Din, then pulses Dlatch, then idles for a gap.
// Accept to Ready takes 18*CLK_DIV+LATCH_CYCLES+GAP_CYCLES+1 cycles; Ready is low for the whole frame, so Valid waits.
module spidlg_tx #(
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 2,
  parameter int GAP_CYCLES   = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [1:0] Cmd,
  input  logic [6:0] Data,
  input  logic       Valid,
  output logic       Ready,
  output logic       Dclk,
  output logic       Din,
  output logic       Dlatch,
  output logic       Done
);

  localparam int DW   = $clog2(CLK_DIV) + 1;
  localparam int PMAX = (LATCH_CYCLES > GAP_CYCLES) ? LATCH_CYCLES : GAP_CYCLES;
  localparam int PW   = $clog2(PMAX) + 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    GAP
  } state_t;

  state_t          state, state_nxt;
  logic [8:0]      sr, sr_nxt;
  logic [3:0]      bit_cnt, bit_cnt_nxt;
  logic [DW-1:0]   div_cnt;
  logic [PW-1:0]   ph_cnt;
  logic            run;
  logic            div_last;

  assign div_last = (div_cnt == DIV_LAST);

  // run stays low through the edge that releases reset, so a Valid present then is not taken
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      ph_cnt  <= '0;
      run     <= 1'b0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      bit_cnt <= bit_cnt_nxt;
      run     <= 1'b1;
      if (state_nxt != state) begin
        div_cnt <= '0;
        ph_cnt  <= '0;
      end else begin
        if (state == SHIFT_LO || state == SHIFT_HI) div_cnt <= div_cnt + 1'b1;
        if (state == LATCH || state == GAP)         ph_cnt  <= ph_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    Ready       = 1'b0;
    Dclk        = 1'b0;
    Din         = 1'b0;
    Dlatch      = 1'b0;
    Done        = 1'b0;
    case (state)
      IDLE: begin
        Ready = 1'b1;
        if (Valid && run) begin
          sr_nxt      = {Cmd, Data};
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        Din = sr[8];
        if (div_last) state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        Dclk = 1'b1;
        Din  = sr[8];
        if (div_last) begin
          if (bit_cnt == 4'd8) begin
            state_nxt = LATCH;
          end else begin
            // next bit appears together with the falling Dclk
            sr_nxt      = {sr[7:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 4'd1;
            state_nxt   = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        Dlatch = 1'b1;
        if (ph_cnt == LATCH_LAST) state_nxt = GAP;
      end
      GAP: begin
        if (ph_cnt == GAP_LAST) begin
          Done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spidlg_tx.sv
// Bench for spidlg_tx: default and fast (1/1/3) instances, each with a behavioural display receiver and frame scoreboard.
module tb_spidlg_tx;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [1:0] valid, ready, dclk, din, dlatch, done;
  logic [1:0] cmd  [2];
  logic [6:0] data [2];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] rx0, rx1;
  int         rises [2];
  int         latch_n [2];
  logic       din_prev1;

  typedef struct {
    int         sel;
    logic [1:0] cmd;
    logic [6:0] data;
    logic [8:0] frame;
  } vec_t;
  vec_t vecs [5];

  spidlg_tx u_def (
    .Clk(Clk), .Rst_n(Rst_n), .Cmd(cmd[0]), .Data(data[0]), .Valid(valid[0]),
    .Ready(ready[0]), .Dclk(dclk[0]), .Din(din[0]), .Dlatch(dlatch[0]), .Done(done[0])
  );

  spidlg_tx #(.CLK_DIV(1), .LATCH_CYCLES(1), .GAP_CYCLES(3)) u_fast (
    .Clk(Clk), .Rst_n(Rst_n), .Cmd(cmd[1]), .Data(data[1]), .Valid(valid[1]),
    .Ready(ready[1]), .Dclk(dclk[1]), .Din(din[1]), .Dlatch(dlatch[1]), .Done(done[1])
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  initial begin
    rises[0] = 0; rises[1] = 0; latch_n[0] = 0; latch_n[1] = 0;
    rx0 = '0; rx1 = '0;
  end

  // Behavioural receivers: shift on Dclk rise, latch on Dlatch rise
  always @(posedge dclk[0]) begin
    rx0 <= {rx0[7:0], din[0]};
    rises[0]++;
  end
  always @(posedge dclk[1]) begin
    rx1 <= {rx1[7:0], din[1]};
    rises[1]++;
    check("din_stable_fast", din[1], din_prev1);
  end
  always @(negedge Clk) din_prev1 <= din[1];

  always @(posedge dlatch[0]) begin
    latch_n[0]++;
    if (exp_q0.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL latch_unexpected_def: got latch with frame %0h, required no latch", rx0);
    end else check("frame_def", rx0, exp_q0.pop_front());
  end
  always @(posedge dlatch[1]) begin
    latch_n[1]++;
    if (exp_q1.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL latch_unexpected_fast: got latch with frame %0h, required no latch", rx1);
    end else check("frame_fast", rx1, exp_q1.pop_front());
  end

  task automatic start(input int sel, input logic [1:0] c, input logic [6:0] d, input logic [8:0] f);
    int k = 0;
    while (ready[sel] !== 1'b1 && k < 400) begin
      @(negedge Clk);
      k++;
    end
    if (k >= 400) begin
      n_cmp++; n_fail++;
      $display("FAIL start_timeout sel=%0d: got ready=0, required 1", sel);
    end
    cmd[sel]   = c;
    data[sel]  = d;
    valid[sel] = 1'b1;
    if (sel == 0) exp_q0.push_back(f); else exp_q1.push_back(f);
    @(posedge Clk);
  endtask

  // Follows one frame from the accept edge; scrambles inputs while busy unless hold is set
  task automatic finish(input int sel, input bit hold);
    int   n = 0, done_at = -1, ready_at = -1, done_cnt = 0, latch_cyc = 0, tog_ok = 0;
    int   r0 = rises[sel];
    int   l0 = latch_n[sel];
    int   ft = (sel == 0) ? 79 : 23;
    int   lc = (sel == 0) ? 2 : 1;
    logic exp_clk;
    while (n < 400) begin
      @(negedge Clk);
      n++;
      if (done[sel]) begin done_cnt++; done_at = n; end
      if (dlatch[sel]) latch_cyc++;
      exp_clk = (n % 2 == 0);
      if (sel == 1 && n <= 18 && dclk[1] == exp_clk) tog_ok++;
      if (ready[sel]) begin ready_at = n; break; end
      if (!hold) begin
        valid[sel] = 1'($urandom_range(0, 1));
        cmd[sel]   = 2'($urandom);
        data[sel]  = 7'($urandom);
      end
    end
    if (!hold) valid[sel] = 1'b0;
    check("done_at", done_at, ft - 1);
    check("ready_at", ready_at, ft);
    check("done_width", done_cnt, 1);
    check("latch_width", latch_cyc, lc);
    check("dclk_rises", rises[sel] - r0, 9);
    check("latch_pulses", latch_n[sel] - l0, 1);
    check("sb_drained", (sel == 0) ? exp_q0.size() : exp_q1.size(), 0);
    if (sel == 1) check("dclk_toggle", tog_ok, 18);
  endtask

  initial begin
    int r0, l0;
    vecs[0] = '{0, 2'd1, 7'h41, 9'h0C1};
    vecs[1] = '{0, 2'd0, 7'h00, 9'h000};
    vecs[2] = '{1, 2'd1, 7'h41, 9'h0C1};
    vecs[3] = '{1, 2'd3, 7'h7F, 9'h1FF};
    vecs[4] = '{1, 2'd2, 7'h2A, 9'h12A};

    Rst_n = 1'b0;
    valid = '0;
    cmd[0] = '0; cmd[1] = '0; data[0] = '0; data[1] = '0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);

    // reset asserted while idle, checked between edges
    #2 Rst_n = 1'b0;
    #1;
    check("rst_outs_def",  {dclk[0], din[0], dlatch[0], done[0], ready[0]}, 5'b00001);
    check("rst_outs_fast", {dclk[1], din[1], dlatch[1], done[1], ready[1]}, 5'b00001);
    @(negedge Clk);
    Rst_n = 1'b1;
    r0 = rises[0] + rises[1];
    repeat (3) @(negedge Clk);
    check("idle_no_dclk", rises[0] + rises[1] - r0, 0);

    for (int i = 0; i < 5; i++) begin
      start(vecs[i].sel, vecs[i].cmd, vecs[i].data, vecs[i].frame);
      finish(vecs[i].sel, 1'b0);
    end

    // back-to-back with Valid held: second accept on the first Ready cycle
    l0 = latch_n[0];
    start(0, 2'd3, 7'h05, 9'h185);
    finish(0, 1'b1);
    start(0, 2'd2, 7'h5A, 9'h15A);
    finish(0, 1'b0);
    check("b2b_latches", latch_n[0] - l0, 2);

    // reset after the 4th Dclk rise abandons the frame
    l0 = latch_n[0];
    start(0, 2'd3, 7'h7F, 9'h1FF);
    r0 = rises[0];
    for (int k = 0; k < 200 && rises[0] - r0 < 4; k++) @(negedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    check("abort_outs", {dclk[0], din[0], dlatch[0], ready[0]}, 4'b0001);
    exp_q0.delete();
    valid[0] = 1'b0;
    @(negedge Clk);
    check("abort_no_latch", latch_n[0] - l0, 0);

    // Valid present on the release edge must wait one more edge
    Rst_n    = 1'b1;
    cmd[0]   = 2'd1;
    data[0]  = 7'h30;
    valid[0] = 1'b1;
    exp_q0.push_back(9'h0B0);
    @(posedge Clk);
    @(negedge Clk);
    check("release_ignored", ready[0], 1);
    @(posedge Clk);
    finish(0, 1'b0);
    check("after_abort_latches", latch_n[0] - l0, 1);

    repeat (2) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "timeout");
  end

endmodule
